// File: rtl/divisor_secuencial_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master drives requests; the slave (the divider) returns results.
interface divisor_secuencial_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  inicio;
  logic                  con_signo;
  logic [DATA_WIDTH-1:0] dividendo;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  ocupado;
  logic                  listo;
  logic [DATA_WIDTH-1:0] cociente;
  logic [DATA_WIDTH-1:0] residuo;
  logic                  div_cero;

  modport master (
    output inicio, con_signo, dividendo, divisor,
    input  ocupado, listo, cociente, residuo, div_cero
  );

  modport slave (
    input  inicio, con_signo, dividendo, divisor,
    output ocupado, listo, cociente, residuo, div_cero
  );
endinterface

// File: rtl/divisor_secuencial.sv
// Iterative restoring divider: one shift-subtract step per cycle on operand magnitudes,
// sign correction at the end, quotient/remainder held until the next accepted request.
module divisor_secuencial #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  divisor_secuencial_if.slave   bus_io
);
  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e          state_q, state_d;
  logic            load_en, step_en, fin_en, ocupado;

  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dvsr_q, dvsr_d;
  logic [W-1:0]    dvnd_q, dvnd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            zero_q, zero_d;
  logic [W-1:0]    coc_q, coc_d;
  logic [W-1:0]    res_q, res_d;
  logic            dz_q, dz_d;
  logic            listo_q, listo_d;

  logic [W-1:0]    dvnd_abs, dvsr_abs;
  logic [W:0]      rem_sh;
  logic            ge;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus_io.inicio) state_d = StCalc;
      StCalc:  if (cnt_q == '0) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    load_en = 1'b0;
    step_en = 1'b0;
    fin_en  = 1'b0;
    ocupado = 1'b0;
    unique case (state_q)
      StIdle:  load_en = bus_io.inicio;
      StCalc:  begin step_en = 1'b1; ocupado = 1'b1; end
      StFin:   begin fin_en  = 1'b1; ocupado = 1'b1; end
      default: ;
    endcase
  end

  assign dvnd_abs = (bus_io.con_signo && bus_io.dividendo[W-1]) ? -bus_io.dividendo
                                                                 : bus_io.dividendo;
  assign dvsr_abs = (bus_io.con_signo && bus_io.divisor[W-1]) ? -bus_io.divisor
                                                               : bus_io.divisor;
  assign rem_sh   = (rem_q << 1) | {{W{1'b0}}, quo_q[W-1]};
  assign ge       = rem_sh >= {1'b0, dvsr_q};

  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    dvnd_d    = dvnd_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    coc_d     = coc_q;
    res_d     = res_q;
    dz_d      = dz_q;
    listo_d   = fin_en;
    if (load_en) begin
      rem_d     = '0;
      quo_d     = dvnd_abs;
      dvsr_d    = dvsr_abs;
      dvnd_d    = bus_io.dividendo;
      neg_quo_d = bus_io.con_signo && (bus_io.dividendo[W-1] ^ bus_io.divisor[W-1]);
      neg_rem_d = bus_io.con_signo && bus_io.dividendo[W-1];
      zero_d    = (bus_io.divisor == '0);
      // Divide-by-zero still passes through one CALC cycle so listo lands two edges later.
      cnt_d     = (bus_io.divisor == '0) ? '0 : CntW'(W - 1);
    end else if (step_en) begin
      rem_d = ge ? (rem_sh - {1'b0, dvsr_q}) : rem_sh;
      quo_d = {quo_q[W-2:0], ge};
      cnt_d = cnt_q - 1'b1;
    end else if (fin_en) begin
      coc_d = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
      res_d = zero_q ? dvnd_q : (neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0]);
      dz_d  = zero_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dvnd_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      coc_q     <= '0;
      res_q     <= '0;
      dz_q      <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      dvnd_q    <= dvnd_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      coc_q     <= coc_d;
      res_q     <= res_d;
      dz_q      <= dz_d;
      listo_q   <= listo_d;
    end
  end

  assign bus_io.ocupado  = ocupado;
  assign bus_io.listo    = listo_q;
  assign bus_io.cociente = coc_q;
  assign bus_io.residuo  = res_q;
  assign bus_io.div_cero = dz_q;
endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: arithmetic model plus a per-cycle compare process,
// with literal expectations for each directed case.
module tb_divisor_secuencial;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divisor_secuencial_if #(.DATA_WIDTH(W)) bus ();

  divisor_secuencial #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          e;
    int          due;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          checking = 1'b0;
  exp_t        pend[$];
  logic [31:0] held_q = '0;
  logic [31:0] held_r = '0;
  logic        held_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Returns {div_cero, cociente, residuo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb, qq, rr;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (!s) return {1'b0, a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa % sb;
    return {1'b0, qq[31:0], rr[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit el, eb;
    if (!rst && checking) begin
      el = (pend.size() > 0) && (pend[0].due == cyc);
      eb = (pend.size() > 0) && (cyc >= pend[0].e) && (cyc < pend[0].due);
      check("listo", {31'd0, bus.listo}, {31'd0, el});
      check("ocupado", {31'd0, bus.ocupado}, {31'd0, eb});
      if (el) begin
        held_q = pend[0].q;
        held_r = pend[0].r;
        held_z = pend[0].z;
        void'(pend.pop_front());
      end
      check("cociente", bus.cociente, held_q);
      check("residuo", bus.residuo, held_r);
      check("div_cero", {31'd0, bus.div_cero}, {31'd0, held_z});
    end
  end

  // Drives inicio for one edge from the current negedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit accept);
    logic [64:0] m;
    exp_t        x;
    bus.inicio    = 1'b1;
    bus.dividendo = a;
    bus.divisor   = b;
    bus.con_signo = s;
    if (accept) begin
      m     = model(a, b, s);
      x.z   = m[64];
      x.q   = m[63:32];
      x.r   = m[31:0];
      x.e   = cyc + 1;
      x.due = cyc + 1 + (x.z ? 2 : 33);
      pend.push_back(x);
    end
    @(negedge clk);
    bus.inicio = 1'b0;
  endtask

  task automatic wait_listo(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (bus.listo) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL listo_timeout: got no listo expected listo within %0d cycles", maxc);
    end
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [31:0] eq, input logic [31:0] er,
                     input logic ez, input int lat);
    int e;
    e = cyc + 1;
    issue(a, b, s, 1'b1);
    wait_listo(40);
    check({name, "_lat"}, cyc - e, lat);
    check({name, "_q"}, bus.cociente, eq);
    check({name, "_r"}, bus.residuo, er);
    check({name, "_z"}, {31'd0, bus.div_cero}, {31'd0, ez});
  endtask

  initial begin
    logic [64:0] m;
    int          e;
    rst           = 1'b1;
    bus.inicio    = 1'b0;
    bus.con_signo = 1'b0;
    bus.dividendo = '0;
    bus.divisor   = '0;

    m = model(32'd100, 32'd7, 1'b0);
    check("pin_u_q", m[63:32], 32'd14);
    check("pin_u_r", m[31:0], 32'd2);
    m = model(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("pin_s_q", m[63:32], 32'hFFFF_FFFD);
    check("pin_s_r", m[31:0], 32'hFFFF_FFFF);
    m = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("pin_ovf_q", m[63:32], 32'h8000_0000);

    repeat (2) @(negedge clk);
    check("rst_ocupado", {31'd0, bus.ocupado}, 32'd0);
    check("rst_listo", {31'd0, bus.listo}, 32'd0);
    check("rst_q", bus.cociente, 32'd0);
    check("rst_r", bus.residuo, 32'd0);
    check("rst_z", {31'd0, bus.div_cero}, 32'd0);
    rst      = 1'b0;
    checking = 1'b1;
    @(negedge clk);

    run("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    run("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run("sm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run("dz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2);
    run("dz_s", 32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 2);
    run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
    run("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);

    // New request during CALC is ignored; the next one lands in the listo cycle.
    e = cyc + 1;
    issue(32'd1000, 32'd10, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    issue(32'd55, 32'd5, 1'b0, 1'b0);
    wait_listo(40);
    check("busy_lat", cyc - e, 33);
    check("busy_q", bus.cociente, 32'd100);
    check("busy_r", bus.residuo, 32'd0);
    run("b2b", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 33);

    // Asynchronous reset in the middle of CALC.
    issue(32'd50, 32'd3, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    checking = 1'b0;
    rst      = 1'b1;
    #1;
    check("arst_ocupado", {31'd0, bus.ocupado}, 32'd0);
    check("arst_listo", {31'd0, bus.listo}, 32'd0);
    check("arst_q", bus.cociente, 32'd0);
    check("arst_r", bus.residuo, 32'd0);
    check("arst_z", {31'd0, bus.div_cero}, 32'd0);
    pend.delete();
    held_q = '0;
    held_r = '0;
    held_z = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    checking = 1'b1;
    repeat (40) @(negedge clk);
    run("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
